// File: rtl/keypad_scan_if.sv
// -----------------------------------------------------------------------------
// keypad_scan_if
// Pin/consumer bundle of the 4x4 keypad scanner.
//   row       : keypad rows, active-low, asynchronous to clk (driven by the board)
//   col       : column drive, active-low one-hot (driven by the scanner)
//   key_value : code of the last accepted key, 16 = none since reset
//   flag      : one-cycle pulse marking a newly accepted key
// Modports:
//   master : the scanner side (samples row, drives col/key_value/flag)
//   slave  : the board/consumer side
// -----------------------------------------------------------------------------
interface keypad_scan_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [4:0] key_value;
    logic       flag;

    modport master (input row, output col, output key_value, output flag);
    modport slave  (output row, input col, input key_value, input flag);
endinterface

// File: rtl/keypad_scan.sv
// -----------------------------------------------------------------------------
// keypad_scan
// 4x4 matrix keypad scanner and press/release debouncer. Walks an active-low
// column across the matrix, samples the synchronized rows at the end of each
// column dwell, debounces the press, emits one flag pulse with the key code
// (row_idx*4 + col_idx) and then debounces the release before scanning again.
//
// Parameters:
//   SCAN_DIV     : cycles each column is driven before its rows are sampled
//   DEBOUNCE_CNT : consecutive stable cycles to accept a press or a release
//   REPEAT_CNT   : auto-repeat period while a key is held (KEY_REPEAT_EN only)
//
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   kp    : keypad_scan_if.master (row in; col, key_value, flag out)
//
// Build option:
//   KEY_REPEAT_EN : when defined, a held key re-pulses flag every REPEAT_CNT
//                   cycles with key_value unchanged.
// -----------------------------------------------------------------------------
module keypad_scan #(
    parameter logic [15:0] SCAN_DIV     = 16'd1000,
    parameter logic [19:0] DEBOUNCE_CNT = 20'd500000,
    parameter logic [23:0] REPEAT_CNT   = 24'd5000000
) (
    input  logic          clk,
    input  logic          rst_n,
    keypad_scan_if.master kp
);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_PRESS_DB,
        ST_HOLD,
        ST_REL_DB
    } state_t;

    state_t      state;
    logic [3:0]  row_m;
    logic [3:0]  row_s;
    logic [1:0]  col_idx;
    logic [1:0]  row_idx;
    logic [15:0] scan_cnt;
    logic [19:0] db_cnt;
    logic [4:0]  key_value_q;
    logic        flag_q;

`ifdef KEY_REPEAT_EN
    logic [23:0] rep_cnt;
`else
    // Repeat period is meaningless without the repeat feature; fold it into
    // a deliberately unused net so the parameter list stays uniform.
    logic unused_repeat_cnt;
    assign unused_repeat_cnt = ^REPEAT_CNT;
`endif

    // Lowest-index low row wins when several keys share the sampled column.
    function automatic logic [1:0] lowest_low(input logic [3:0] r);
        if (!r[0])      lowest_low = 2'd0;
        else if (!r[1]) lowest_low = 2'd1;
        else if (!r[2]) lowest_low = 2'd2;
        else            lowest_low = 2'd3;
    endfunction

    // Rows idle high, so the synchronizer resets to "no key" rather than 0,
    // which would look like every row pressed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_m <= 4'hF;
            row_s <= 4'hF;
        end else begin
            // NOTE: registers take non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            row_m <= kp.row;
            row_s <= row_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_SCAN;
            col_idx     <= 2'd0;
            row_idx     <= 2'd0;
            scan_cnt    <= 16'd0;
            db_cnt      <= 20'd0;
            key_value_q <= 5'd16;
            flag_q      <= 1'b0;
`ifdef KEY_REPEAT_EN
            rep_cnt     <= 24'd0;
`endif
        end else begin
            flag_q <= 1'b0;
            unique case (state)
                ST_SCAN: begin
                    if (scan_cnt == SCAN_DIV - 16'd1) begin
                        scan_cnt <= 16'd0;
                        if (row_s != 4'hF) begin
                            row_idx <= lowest_low(row_s);
                            db_cnt  <= 20'd0;
                            state   <= ST_PRESS_DB;
                        end else begin
                            col_idx <= col_idx + 2'd1;
                        end
                    end else begin
                        scan_cnt <= scan_cnt + 16'd1;
                    end
                end

                ST_PRESS_DB: begin
                    // Column stays frozen; only the latched row is watched.
                    if (row_s[row_idx]) begin
                        col_idx <= col_idx + 2'd1;
                        state   <= ST_SCAN;
                    end else if (db_cnt == DEBOUNCE_CNT - 20'd1) begin
                        key_value_q <= {1'b0, row_idx, col_idx};
                        flag_q      <= 1'b1;
                        state       <= ST_HOLD;
                    end else begin
                        db_cnt <= db_cnt + 20'd1;
                    end
                end

                ST_HOLD: begin
                    if (row_s == 4'hF) begin
                        db_cnt <= 20'd0;
                        state  <= ST_REL_DB;
`ifdef KEY_REPEAT_EN
                        rep_cnt <= 24'd0;
                    end else if (rep_cnt == REPEAT_CNT - 24'd1) begin
                        flag_q  <= 1'b1;
                        rep_cnt <= 24'd0;
                    end else begin
                        rep_cnt <= rep_cnt + 24'd1;
`endif
                    end
                end

                ST_REL_DB: begin
                    // Any low row means the release was a bounce.
                    if (row_s != 4'hF) begin
                        state <= ST_HOLD;
                    end else if (db_cnt == DEBOUNCE_CNT - 20'd1) begin
                        col_idx  <= 2'd0;
                        scan_cnt <= 16'd0;
                        state    <= ST_SCAN;
                    end else begin
                        db_cnt <= db_cnt + 20'd1;
                    end
                end

                default: state <= ST_SCAN;
            endcase
        end
    end

    assign kp.col       = 4'b1111 ^ (4'b0001 << col_idx);
    assign kp.key_value = key_value_q;
    assign kp.flag      = flag_q;

endmodule
